// File: rtl/cpu_arb_pkg.sv
// Shared arbitration types for the CPU-side request arbiters.
package cpu_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    typedef logic [1:0] req_idx_t;

    localparam int N_REQ = 4;

endpackage

// File: rtl/Mux4x1.sv
// Plain 4:1 datapath mux, SIZE bits wide.
module Mux4x1 #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] In0,
    input  logic [SIZE-1:0] In1,
    input  logic [SIZE-1:0] In2,
    input  logic [SIZE-1:0] In3,
    input  logic [1:0]      sel,
    output logic [SIZE-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = In0;
            2'd1:    out = In1;
            2'd2:    out = In2;
            default: out = In3;
        endcase
    end

endmodule

// File: rtl/rr4_pick.sv
// Combinational 4-way round-robin pick: first set req bit after ptr, wrapping back to ptr itself.
module rr4_pick
    import cpu_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output req_idx_t         win,
    output logic             any
);

    req_idx_t w_idx;

    always_comb begin
        win   = '0;
        w_idx = '0;
        any   = |req;
        // Scan farthest first so the nearest set bit after ptr overwrites and wins.
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = ptr + req_idx_t'(k);
            if (req[w_idx]) win = w_idx;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter4.sv
// Round-robin arbiter sharing one SIZE-bit datapath among four requesters,
// with a per-grant beat cap so no requester can starve the others.
module mux_rr_arbiter4
    import cpu_arb_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [SIZE-1:0]  In0,
    input  logic [SIZE-1:0]  In1,
    input  logic [SIZE-1:0]  In2,
    input  logic [SIZE-1:0]  In3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [SIZE-1:0]  out_data
);

    localparam int                CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t        r_state, w_state_nxt;
    req_idx_t          r_ptr,   w_ptr_nxt;
    req_idx_t          r_sel,   w_sel_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [N_REQ-1:0]  r_gnt,   w_gnt_nxt;

    req_idx_t          w_pick_ptr;
    req_idx_t          w_win;
    logic              w_any;
    logic              w_beat;
    logic              w_release;

    // While granted, arbitrate as if ptr already moved to the owner, so a
    // release can hand over on the same edge with the owner at lowest priority.
    assign w_pick_ptr = (r_state == ARB_GRANT) ? r_sel : r_ptr;

    rr4_pick u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .win (w_win),
        .any (w_any)
    );

    Mux4x1 #(.SIZE(SIZE)) u_mux (
        .In0 (In0),
        .In1 (In1),
        .In2 (In2),
        .In3 (In3),
        .sel (r_sel),
        .out (out_data)
    );

    assign out_valid = (r_gnt != '0) && req[r_sel];
    assign w_beat    = out_valid && out_ready;
    assign w_release = (r_state == ARB_GRANT) &&
                       (!req[r_sel] || (w_beat && (r_cnt == CNT_LAST)));

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_GRANT;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel;
                    w_cnt_nxt = '0;
                    if (w_any) begin
                        w_gnt_nxt = N_REQ'(1) << w_win;
                        w_sel_nxt = w_win;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 2'd3;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign gnt = r_gnt;
    assign sel = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter4.sv
// Directed checks of mux_rr_arbiter4 (SIZE=8, MAX_HOLD=4) against hand-computed grant sequences.
module tb_mux_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] In0 = 8'h11, In1 = 8'h22, In2 = 8'h33, In3 = 8'h44;
    logic       out_ready = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic [7:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    mux_rr_arbiter4 #(.SIZE(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .In0       (In0),
        .In1       (In1),
        .In2       (In2),
        .In3       (In3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one rising edge and land 2 time units after it, clear of the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Assert reset between edges, hold across one edge, release between edges.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // 1. reset state with all requesting
        req = 4'hF;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h11);
        step();
        chk("rst_hold_gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        step();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_sel", 32'(sel), 32'h0);

        // 2. all requesting: 0,1,2,3,0 each for 4 beats, no gaps
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("rr_gnt g%0d b%0d", g, b), 32'(gnt), 32'(4'b0001 << (g % 4)));
                chk($sformatf("rr_sel g%0d b%0d", g, b), 32'(sel), 32'(g % 4));
                chk($sformatf("rr_vld g%0d b%0d", g, b), 32'(out_valid), 32'h1);
                case (g % 4)
                    0: chk("rr_data", 32'(out_data), 32'h11);
                    1: chk("rr_data", 32'(out_data), 32'h22);
                    2: chk("rr_data", 32'(out_data), 32'h33);
                    default: chk("rr_data", 32'(out_data), 32'h44);
                endcase
                step();
            end
        end
        chk("rr_wrap_gnt", 32'(gnt), 32'h2);

        // 3. backpressure: owner 0 held 3 cycles, then exactly 4 beats before req1 wins
        req = 4'b0011;
        In0 = 8'hA5;
        out_ready = 1'b0;
        do_reset();
        step();
        chk("bp_gnt0", 32'(gnt), 32'h1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_vld c%0d", c), 32'(out_valid), 32'h1);
            chk($sformatf("bp_data c%0d", c), 32'(out_data), 32'hA5);
            step();
            chk($sformatf("bp_gnt c%0d", c), 32'(gnt), 32'h1);
        end
        out_ready = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            step();
            chk($sformatf("bp_beat%0d_gnt", b), 32'(gnt), 32'h1);
            chk($sformatf("bp_beat%0d_data", b), 32'(out_data), 32'hA5);
        end
        step();
        chk("bp_handoff_gnt", 32'(gnt), 32'h2);
        chk("bp_handoff_sel", 32'(sel), 32'h1);

        // 4. owner 2 drops req after 2 beats; owner 3 granted with a fresh count
        req = 4'b1100;
        out_ready = 1'b1;
        do_reset();
        step();
        chk("drop_gnt2", 32'(gnt), 32'h4);
        step();
        step();
        chk("drop_gnt2_hold", 32'(gnt), 32'h4);
        req = 4'b1000;
        #1;
        chk("drop_vld_low", 32'(out_valid), 32'h0);
        step();
        chk("drop_gnt3", 32'(gnt), 32'h8);
        chk("drop_sel3", 32'(sel), 32'h3);
        req = 4'b1010;
        for (int b = 1; b <= 3; b++) begin
            step();
            chk($sformatf("drop_cnt%0d_gnt", b), 32'(gnt), 32'h8);
        end
        step();
        chk("drop_next_gnt1", 32'(gnt), 32'h2);

        // 5. lone requester 1 regrants itself; late req0 waits for release
        req = 4'b0010;
        for (int b = 1; b <= 4; b++) begin
            step();
            chk($sformatf("lone_b%0d_gnt", b), 32'(gnt), 32'h2);
        end
        step();
        step();
        chk("lone_regrant_b2", 32'(gnt), 32'h2);
        req = 4'b0011;
        step();
        chk("nopreempt_gnt", 32'(gnt), 32'h2);
        step();
        chk("late_req0_gnt", 32'(gnt), 32'h1);
        chk("late_req0_sel", 32'(sel), 32'h0);

        // 6. async reset mid-grant, then arbitration restarts at requester 0
        req = 4'b1001;
        #1 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_vld", 32'(out_valid), 32'h0);
        chk("async_sel", 32'(sel), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_sel", 32'(sel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
